uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered UART transmitter: a write-side FIFO feeds a framing FSM that serialises 5..8 data bits,
//  optional even/odd parity and 1 or 2 stop bits, paced by an external one-tick-per-bit tx_tick.
//  Adds back-to-back streaming, per-frame CTS gating, 2-stop-bit mode, line-break generation and
//  overflow/level reporting. Sits between the CPU/register interface and the pad.
// PARAMETERS
//  FIFO_DEPTH  16  entries in TX FIFO; power of 2, >= 2
//  LVL_W       $clog2(FIFO_DEPTH+1)  width of o_level (derived localparam, not overridable)
// PORTS
//  clk             in   1      system clock
//  rst_n           in   1      asynchronous active-low reset
//  tx_tick         in   1      one-clk pulse per bit period
//  i_num_bit_data  in   2      00:5, 01:6, 10:7, 11:8 data bits
//  i_parity_en     in   1      1: append parity bit
//  i_parity_type   in   1      0: even, 1: odd
//  i_stop_bits     in   1      0: one stop bit, 1: two
//  i_break         in   1      1: hold line low (break) once FSM is idle
//  i_cts_n         in   1      0: clear to send; sampled only at frame start
//  i_wr_en         in   1      push i_wr_data into FIFO
//  i_wr_data       in   8      byte to send (LSB first; bits above width ignored)
//  o_full          out  1      FIFO full
//  o_empty         out  1      FIFO empty
//  o_level         out  LVL_W  FIFO occupancy
//  o_overflow      out  1      one-clk pulse: write dropped because FIFO full
//  o_tx_serial     out  1      serial line, idle high
//  o_tx_busy       out  1      FSM not IDLE
//  o_tx_done       out  1      one-clk pulse on tick that ends the last stop bit
// BEHAVIOUR
//  - Reset (async): FIFO emptied, o_empty=1, o_full=0, o_level=0, o_tx_serial=1, busy/done/overflow=0, FSM=IDLE.
//  - Write: i_wr_en && !o_full pushes on clk edge; i_wr_en && o_full drops data, pulses o_overflow,
//    even if a pop occurs same cycle. Same-cycle push+pop when not full: level unchanged.
//  - FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK; all transitions only on tx_tick.
//  - IDLE: on tx_tick, if i_break=1 -> BREAK (line 0); else if !o_empty && !i_cts_n -> pop head,
//    latch data and all config, drive 0, -> START. Break has priority over pending data.
//  - START -> DATA; DATA shifts LSB first, N=5+num_bit ticks; -> PARITY if latched parity_en else STOP1.
//  - PARITY bit = XOR of the N sent bits, inverted if odd. STOP1/STOP2 drive 1; STOP2 only if 2-stop latched.
//  - Last stop tick: o_tx_done pulses; if !o_empty && !i_cts_n && !i_break, pop and start next frame in
//    the same tick (no idle bit between frames); else -> IDLE.
//  - BREAK: line 0 while i_break=1; on tx_tick with i_break=0 -> line 1, IDLE (one idle bit min).
//  - Config and CTS changes mid-frame have no effect on the frame in flight; CTS never aborts a frame.
//  - o_tx_serial is registered; changes exactly on the clk edge where tx_tick is sampled high.
//  - Latency: first write into empty FIFO, idle line -> start bit begins on the next tx_tick.
// STRUCTURE
//  - uart_pkg: state enum tx_state_e, DATA_BITS encoding constants, parity type constants.
//  - Sub-module uart_sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): full/empty/level, registered outputs.
//  - Top: FIFO instance, framing FSM, shift register, bit counter, parity accumulator.
// TESTING (tx_tick every 16 clk, clk 50 MHz; bit sampled mid-bit)
//  - 8N1, write 0x55 -> line: 0,1,0,1,0,1,0,1,0,1 then idle 1; one o_tx_done; o_level 1->0.
//  - 8E2, burst 0xAA,0x01,0xFF -> three frames back-to-back, parity 0,1,0, two stop bits each, 3 done pulses.
//  - 5O1, write 0xFF -> 5 ones, parity 0, stop; upper 3 bits never transmitted.
//  - FIFO_DEPTH=4, CTS_n=1, write 6 bytes -> o_full after 4, 2 o_overflow pulses, line stays 1;
//    release CTS -> exactly 4 frames in order.
//  - CTS raised mid-frame 2 of 3 -> frame 2 completes, frame 3 held until CTS low.
//  - i_break during frame -> frame completes, line low while break held, then >=1 idle bit;
//    rst_n low mid-frame -> o_tx_serial=1 immediately, FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
//   tx_state_e    framing FSM states
//   DataBits*     i_num_bit_data encodings
//   Parity*       i_parity_type encodings
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBreak
  } tx_state_e;

  localparam logic [1:0] DataBits5 = 2'b00;
  localparam logic [1:0] DataBits6 = 2'b01;
  localparam logic [1:0] DataBits7 = 2'b10;
  localparam logic [1:0] DataBits8 = 2'b11;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // Number of data bits carried by a frame for a given encoding.
  function automatic logic [3:0] data_bits(input logic [1:0] enc);
    logic [3:0] n;
    case (enc)
      DataBits5: n = 4'd5;
      DataBits6: n = 4'd6;
      DataBits7: n = 4'd7;
      DataBits8: n = 4'd8;
      default:   n = 4'd8;
    endcase
    return n;
  endfunction

  // Parity bit from the XOR of the sent data bits.
  function automatic logic parity_bit(input logic acc, input logic ptype);
    logic p;
    case (ptype)
      ParityEven: p = acc;
      ParityOdd:  p = ~acc;
      default:    p = acc;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level flags and an overflow pulse.
//   clk, rst_n     clock, asynchronous active-low reset
//   wr_en_i        push wr_data_i unless full (dropped writes pulse overflow_o)
//   rd_en_i        pop head; rd_data_o always shows the current head
//   full_o         occupancy == DEPTH
//   empty_o        occupancy == 0
//   level_o        occupancy
//   overflow_o     one-cycle pulse after a write attempted while full
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, empty_q, overflow_q;
  logic             push, pop;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push = wr_en_i & ~full_q;
  assign pop  = rd_en_i & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      full_q     <= (level_d == LvlW'(DEPTH));
      empty_q    <= (level_d == '0);
      overflow_q <= wr_en_i & full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: TX FIFO feeding a framing FSM paced by tx_tick.
//   clk, rst_n        clock, asynchronous active-low reset
//   tx_tick           one-clock pulse per bit period
//   i_num_bit_data    data bits 5..8; i_parity_en/i_parity_type parity; i_stop_bits 1 or 2
//   i_break           hold line low once idle; i_cts_n clear-to-send, checked at frame start
//   i_wr_en/i_wr_data FIFO push
//   o_full/o_empty/o_level/o_overflow  FIFO status
//   o_tx_serial       registered serial line (idle high)
//   o_tx_busy         FSM not idle; o_tx_done pulse at the end of the last stop bit
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tx_tick,
  input  logic [1:0]                        i_num_bit_data,
  input  logic                              i_parity_en,
  input  logic                              i_parity_type,
  input  logic                              i_stop_bits,
  input  logic                              i_break,
  input  logic                              i_cts_n,
  input  logic                              i_wr_en,
  input  logic [7:0]                        i_wr_data,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_overflow,
  output logic                              o_tx_serial,
  output logic                              o_tx_busy,
  output logic                              o_tx_done
);

  logic [7:0] fifo_rd_data;
  logic       pop;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (i_wr_en),
    .wr_data_i  (i_wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (o_full),
    .empty_o    (o_empty),
    .level_o    (o_level),
    .overflow_o (o_overflow)
  );

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;      // data bits already driven in this frame
  logic [3:0] nbits_q, nbits_d;
  logic       par_q, par_d;
  logic       pe_q, pe_d, pt_q, pt_d, sb_q, sb_d;
  logic       serial_q, serial_d;
  logic       done_q, done_d;
  logic       can_start, start_frame, frame_end;

  assign can_start = ~o_empty & ~i_cts_n;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    nbits_d     = nbits_q;
    par_d       = par_q;
    pe_d        = pe_q;
    pt_d        = pt_q;
    sb_d        = sb_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    frame_end   = 1'b0;

    if (tx_tick) begin
      case (state_q)
        StIdle: begin
          if (i_break) begin
            state_d  = StBreak;
            serial_d = 1'b0;
          end else if (can_start) begin
            start_frame = 1'b1;
          end
        end
        StStart: begin
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
          par_d    = par_q ^ shift_q[0];
          cnt_d    = 4'd1;
          state_d  = StData;
        end
        StData: begin
          if (cnt_q == nbits_q) begin
            if (pe_q) begin
              serial_d = parity_bit(par_q, pt_q);
              state_d  = StParity;
            end else begin
              serial_d = 1'b1;
              state_d  = StStop1;
            end
          end else begin
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
            par_d    = par_q ^ shift_q[0];
            cnt_d    = cnt_q + 1'b1;
          end
        end
        StParity: begin
          serial_d = 1'b1;
          state_d  = StStop1;
        end
        StStop1: begin
          if (sb_q) state_d = StStop2;
          else      frame_end = 1'b1;
        end
        StStop2: frame_end = 1'b1;
        StBreak: begin
          if (!i_break) begin
            serial_d = 1'b1;
            state_d  = StIdle;
          end
        end
        default: begin
          serial_d = 1'b1;
          state_d  = StIdle;
        end
      endcase

      // Streaming: the next start bit follows the last stop bit with no idle gap.
      if (frame_end) begin
        done_d = 1'b1;
        if (can_start && !i_break) begin
          start_frame = 1'b1;
        end else begin
          serial_d = 1'b1;
          state_d  = StIdle;
        end
      end

      // Data and all framing options are frozen for the whole frame here.
      if (start_frame) begin
        pop      = 1'b1;
        shift_d  = fifo_rd_data;
        nbits_d  = data_bits(i_num_bit_data);
        pe_d     = i_parity_en;
        pt_d     = i_parity_type;
        sb_d     = i_stop_bits;
        cnt_d    = '0;
        par_d    = 1'b0;
        serial_d = 1'b0;
        state_d  = StStart;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      cnt_q    <= '0;
      nbits_q  <= 4'd8;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      sb_q     <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
      par_q    <= par_d;
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      sb_q     <= sb_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_busy   = (state_q != StIdle);
  assign o_tx_done   = done_q;

endmodule
